// File: rtl/seg_score_reader_if.sv
// Segment bus and readback results exchanged with seg_score_reader.
// The master drives the digit segments; the slave is the reader.
interface seg_score_reader_if;
   logic [6:0] seg_tens_i;
   logic [6:0] seg_ones_i;
   logic [3:0] tens_o;
   logic [3:0] ones_o;
   logic [6:0] score_o;
   logic       valid_o;
   logic       update_o;
   logic       inc_o;
   logic       zero_o;
   logic       jump_o;
   logic       error_o;
   logic [7:0] err_count_o;

   modport master (
      output seg_tens_i, seg_ones_i,
      input  tens_o, ones_o, score_o, valid_o, update_o,
      input  inc_o, zero_o, jump_o, error_o, err_count_o
   );

   modport slave (
      input  seg_tens_i, seg_ones_i,
      output tens_o, ones_o, score_o, valid_o, update_o,
      output inc_o, zero_o, jump_o, error_o, err_count_o
   );
endinterface

// File: rtl/seg_score_reader.sv
// Debounced two-digit seven-segment score readback with change classification.
// Define SEG_READER_ERRCNT_EN to build the saturating undecodable-pattern counter.
module seg_score_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic clk_1khz_i,
   input logic rst_i,
   seg_score_reader_if.slave bus
);

   localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

   // {legal, bcd}; anything outside the ten glyphs is illegal
   function automatic logic [4:0] dec7(input logic [6:0] s);
      case (s)
         7'h3F:   dec7 = 5'h10;
         7'h06:   dec7 = 5'h11;
         7'h5B:   dec7 = 5'h12;
         7'h4F:   dec7 = 5'h13;
         7'h66:   dec7 = 5'h14;
         7'h6D:   dec7 = 5'h15;
         7'h7D:   dec7 = 5'h16;
         7'h07:   dec7 = 5'h17;
         7'h7F:   dec7 = 5'h18;
         7'h6F:   dec7 = 5'h19;
         default: dec7 = 5'h00;
      endcase
   endfunction

   logic [13:0] samp;
   logic [7:0]  run;
   logic        fire;
   logic [3:0]  tens_q, ones_q;
   logic [6:0]  score_q;
   logic        valid_q, update_q, inc_q, zero_q, jump_q, error_q;

   logic [13:0] pat;
   logic        differs;
   logic [4:0]  t_dec, o_dec;
   logic        off, legal;
   logic [6:0]  nv;
   logic        changed, is_inc;

   assign pat     = {bus.seg_tens_i, bus.seg_ones_i};
   assign differs = pat != samp;
   assign t_dec   = dec7(samp[13:7]);
   assign o_dec   = dec7(samp[6:0]);
   assign off     = samp == 14'd0;
   // a blank tens digit reads as a leading zero
   assign legal   = (t_dec[4] | (samp[13:7] == 7'd0)) & o_dec[4];
   assign nv      = {t_dec[3:0], 3'b000}
                  + {2'b00, t_dec[3:0], 1'b0}
                  + {3'b000, o_dec[3:0]};
   assign changed = !valid_q || (nv != score_q);
   assign is_inc  = valid_q && (nv == score_q + 7'd1);

   always_ff @(posedge clk_1khz_i) begin
      if (rst_i) begin
         samp     <= '0;
         run      <= '0;
         fire     <= 1'b0;
         tens_q   <= '0;
         ones_q   <= '0;
         score_q  <= '0;
         valid_q  <= 1'b0;
         update_q <= 1'b0;
         inc_q    <= 1'b0;
         zero_q   <= 1'b0;
         jump_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         samp     <= pat;
         update_q <= 1'b0;
         inc_q    <= 1'b0;
         zero_q   <= 1'b0;
         jump_q   <= 1'b0;
         if (differs)
            run <= 8'd1;
         else if (run != STAB)
            run <= run + 8'd1;
         // high exactly in the cycle the run first reaches STAB
         fire <= !differs && (run == STAB - 8'd1);
         if (fire && !off) begin
            if (!legal) begin
               error_q <= 1'b1;
            end else if (changed) begin
               tens_q   <= t_dec[3:0];
               ones_q   <= o_dec[3:0];
               score_q  <= nv;
               valid_q  <= 1'b1;
               update_q <= 1'b1;
               zero_q   <= nv == 7'd0;
               inc_q    <= (nv != 7'd0) && is_inc;
               jump_q   <= (nv != 7'd0) && !is_inc;
            end
         end
      end
   end

   assign bus.tens_o   = tens_q;
   assign bus.ones_o   = ones_q;
   assign bus.score_o  = score_q;
   assign bus.valid_o  = valid_q;
   assign bus.update_o = update_q;
   assign bus.inc_o    = inc_q;
   assign bus.zero_o   = zero_q;
   assign bus.jump_o   = jump_q;
   assign bus.error_o  = error_q;

`ifdef SEG_READER_ERRCNT_EN
   logic [7:0] err_cnt;

   always_ff @(posedge clk_1khz_i) begin
      if (rst_i)
         err_cnt <= '0;
      else if (fire && !off && !legal && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end

   assign bus.err_count_o = err_cnt;
`else
   assign bus.err_count_o = '0;
`endif

endmodule

// File: tb/tb_seg_score_reader.sv
// Scoreboard bench for seg_score_reader: directed segment patterns,
// expected commits queued at stimulus time and checked by a monitor.
module tb_seg_score_reader;
   localparam int S = 4;
   localparam logic [2:0] ZERO = 3'b100;
   localparam logic [2:0] INC  = 3'b010;
   localparam logic [2:0] JUMP = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   seg_score_reader_if sif ();

   seg_score_reader #(.STABLE_CYCLES(S)) dut (
      .clk_1khz_i (clk),
      .rst_i      (rst),
      .bus        (sif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct {
      int         cyc;
      logic [6:0] score;
      logic [3:0] t;
      logic [3:0] o;
      logic [2:0] cls;
   } exp_t;

   exp_t q[$];

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (sif.update_o) begin
            if (q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL spurious_update: got score %0d want none",
                        sif.score_o);
            end else begin
               e = q.pop_front();
               check("upd_cycle", cyc, e.cyc);
               check("upd_score", {25'd0, sif.score_o}, {25'd0, e.score});
               check("upd_tens", {28'd0, sif.tens_o}, {28'd0, e.t});
               check("upd_ones", {28'd0, sif.ones_o}, {28'd0, e.o});
               check("upd_class",
                     {29'd0, sif.zero_o, sif.inc_o, sif.jump_o},
                     {29'd0, e.cls});
            end
         end else if (sif.zero_o | sif.inc_o | sif.jump_o) begin
            n_vec++;
            n_miss++;
            $display("FAIL stray_class: got %b%b%b want 000",
                     sif.zero_o, sif.inc_o, sif.jump_o);
         end
      end
   end

   task automatic push(int at, logic [6:0] sc, logic [2:0] cls);
      exp_t e;
      e.cyc   = at + 1 + S;
      e.score = sc;
      e.t     = 4'(sc / 7'd10);
      e.o     = 4'(sc % 7'd10);
      e.cls   = cls;
      q.push_back(e);
   endtask

   // Pattern is captured on exactly n edges before the next apply.
   task automatic apply(logic [6:0] t, logic [6:0] o, int n,
                        bit commit, logic [6:0] sc, logic [2:0] cls);
      @(posedge clk);
      #1;
      sif.seg_tens_i = t;
      sif.seg_ones_i = o;
      if (commit) push(cyc, sc, cls);
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic check_reset(string tag);
      check({tag, "_tens"},  {28'd0, sif.tens_o}, 32'd0);
      check({tag, "_ones"},  {28'd0, sif.ones_o}, 32'd0);
      check({tag, "_score"}, {25'd0, sif.score_o}, 32'd0);
      check({tag, "_valid"}, {31'd0, sif.valid_o}, 32'd0);
      check({tag, "_pulses"},
            {28'd0, sif.update_o, sif.zero_o, sif.inc_o, sif.jump_o},
            32'd0);
      check({tag, "_error"}, {31'd0, sif.error_o}, 32'd0);
      check({tag, "_errcnt"}, {24'd0, sif.err_count_o}, 32'd0);
   endtask

   int err1, err2;

   initial begin
`ifdef SEG_READER_ERRCNT_EN
      err1 = 1;
      err2 = 2;
`else
      err1 = 0;
      err2 = 0;
`endif
      sif.seg_tens_i = 7'h00;
      sif.seg_ones_i = 7'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("rst");
      rst = 1'b0;

      apply(7'h00, 7'h3F, 8, 1, 7'd0, ZERO);
      @(negedge clk);
      check("first_valid", {31'd0, sif.valid_o}, 32'd1);

      apply(7'h00, 7'h00, 8, 0, 7'd0, 3'b0);
      @(negedge clk);
      check("off_error", {31'd0, sif.error_o}, 32'd0);
      check("off_valid", {31'd0, sif.valid_o}, 32'd1);

      apply(7'h00, 7'h06, 8, 1, 7'd1, INC);
      apply(7'h3F, 7'h07, 8, 1, 7'd7, JUMP);
      apply(7'h3F, 7'h7F, 8, 1, 7'd8, INC);
      apply(7'h6D, 7'h66, 8, 1, 7'd54, JUMP);
      apply(7'h06, 7'h5B, 8, 1, 7'd12, JUMP);

      apply(7'h06, 7'h4F, 3, 0, 7'd0, 3'b0);
      apply(7'h06, 7'h5B, 8, 0, 7'd0, 3'b0);
      @(negedge clk);
      check("glitch_score", {25'd0, sif.score_o}, 32'd12);

      apply(7'h3F, 7'h01, 10, 0, 7'd0, 3'b0);
      @(negedge clk);
      check("bad_error", {31'd0, sif.error_o}, 32'd1);
      check("bad_errcnt", {24'd0, sif.err_count_o}, err1);
      check("bad_score", {25'd0, sif.score_o}, 32'd12);

      apply(7'h06, 7'h00, 8, 0, 7'd0, 3'b0);
      @(negedge clk);
      check("blank_ones_errcnt", {24'd0, sif.err_count_o}, err2);

      apply(7'h6F, 7'h6F, 8, 1, 7'd99, JUMP);
      apply(7'h3F, 7'h3F, 8, 1, 7'd0, ZERO);
      apply(7'h00, 7'h3F, 8, 0, 7'd0, 3'b0);
      apply(7'h00, 7'h00, 10, 0, 7'd0, 3'b0);
      @(negedge clk);
      check("off2_score", {25'd0, sif.score_o}, 32'd0);
      check("off2_error", {31'd0, sif.error_o}, 32'd1);
      check("off2_errcnt", {24'd0, sif.err_count_o}, err2);

      apply(7'h06, 7'h06, 2, 0, 7'd0, 3'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      push(cyc, 7'd11, JUMP);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("final_score", {25'd0, sif.score_o}, 32'd11);
      check("pending_commits", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
